// File: rtl/kv_mem_pkg.sv
// rtl/kv_mem_pkg.sv - shared types and helpers for the cache-line memory arbiter
// Contents:
//   state_e    : arbiter FSM states (IDLE, ISSUE, WAIT, RETURN)
//   line_width : bits in one cache line from word width and words per line
package kv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_e;

    function automatic int line_width(input int data_width, input int line_size);
        return data_width * line_size;
    endfunction

endpackage

// File: rtl/kv_mem_arbiter_if.sv
// rtl/kv_mem_arbiter_if.sv - requester and memory-side bundle of the line arbiter
// Signals (direction as seen by the arbiter):
//   i_req_valid/o_req_ready/i_req_addr/i_req_we/i_req_wdata : per-requester command
//   o_rsp_valid/i_rsp_ready/o_rsp_data                      : per-requester response
//   o_mem_valid/i_mem_ready/o_mem_addr/o_mem_we/o_mem_wdata : memory command
//   i_mem_rvalid/o_mem_rready/i_mem_rdata                   : memory response
// Modports: master = arbiter side, slave = requesters + memory side.
interface kv_mem_arbiter_if
    import kv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4,
    parameter int REQ_NUM    = 2,
    parameter int LINE_WIDTH = line_width(DATA_WIDTH, LINE_SIZE)
) ();

    logic [REQ_NUM-1:0]                 i_req_valid;
    logic [REQ_NUM-1:0]                 o_req_ready;
    logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] i_req_addr;
    logic [REQ_NUM-1:0]                 i_req_we;
    logic [REQ_NUM-1:0][LINE_WIDTH-1:0] i_req_wdata;

    logic [REQ_NUM-1:0]                 o_rsp_valid;
    logic [REQ_NUM-1:0]                 i_rsp_ready;
    logic [LINE_WIDTH-1:0]              o_rsp_data;

    logic                               o_mem_valid;
    logic                               i_mem_ready;
    logic [ADDR_WIDTH-1:0]              o_mem_addr;
    logic                               o_mem_we;
    logic [LINE_WIDTH-1:0]              o_mem_wdata;
    logic                               i_mem_rvalid;
    logic                               o_mem_rready;
    logic [LINE_WIDTH-1:0]              i_mem_rdata;

    modport master (
        input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_rsp_ready,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_data,
        output o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_rready
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_rsp_ready,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_data,
        input  o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_rready
    );

endinterface

// File: rtl/kv_rr_arbiter.sv
// rtl/kv_rr_arbiter.sv - combinational round-robin pick from a request vector
// Ports:
//   i_req         : request vector
//   i_ptr         : highest-priority index this cycle
//   o_grant       : one-hot grant (zero when no request)
//   o_grant_idx   : binary index of the granted requester
//   o_grant_valid : any request present
module kv_rr_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = 1
) (
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [REQ_NUM-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    logic [REQ_NUM-1:0] hi_req;
    logic [REQ_NUM-1:0] pick;
    logic [REQ_NUM-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;

    always_comb begin
        hi_req    = '0;
        grant_idx = '0;
        // Requests at or above the pointer win; if none, wrap to the lowest index.
        for (int i = 0; i < REQ_NUM; i++) begin
            hi_req[i] = i_req[i] && (IDX_W'(i) >= i_ptr);
        end
        pick  = (|hi_req) ? hi_req : i_req;
        // Isolate the lowest set bit of the chosen vector.
        grant = pick & (~pick + REQ_NUM'(1));
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign o_grant       = grant;
    assign o_grant_idx   = grant_idx;
    assign o_grant_valid = |i_req;

endmodule

// File: rtl/kv_mem_arbiter.sv
// rtl/kv_mem_arbiter.sv - round-robin single-outstanding arbiter onto one line-wide memory port
// Ports:
//   i_clk  : clock
//   i_rstn : asynchronous active-low reset
//   bus    : requester command/response and memory command/response (master modport)
// One transaction at a time: accept in IDLE, present command in ISSUE, collect the
// memory response in WAIT, hand it to the owner in RETURN.
module kv_mem_arbiter
    import kv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4,
    parameter int REQ_NUM    = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    kv_mem_arbiter_if.master  bus
);

    localparam int LINE_WIDTH = line_width(DATA_WIDTH, LINE_SIZE);
    localparam int IDX_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

    logic [REQ_NUM-1:0]     grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_vld;

    logic [REQ_NUM-1:0]     req_ready;
    logic [REQ_NUM-1:0]     rsp_valid;
    logic                   mem_valid;
    logic                   mem_rready;

    kv_rr_arbiter #(
        .REQ_NUM (REQ_NUM),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req         (bus.i_req_valid),
        .i_ptr         (ptr_q),
        .o_grant       (grant_oh),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_vld)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        req_ready  = '0;
        rsp_valid  = '0;
        mem_valid  = 1'b0;
        mem_rready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready goes only to the grant, so a grant is also a handshake.
                req_ready = grant_oh;
                if (grant_vld) begin
                    addr_d  = bus.i_req_addr[grant_idx];
                    we_d    = bus.i_req_we[grant_idx];
                    wdata_d = bus.i_req_wdata[grant_idx];
                    owner_d = grant_idx;
                    if (grant_idx == IDX_W'(REQ_NUM - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + IDX_W'(1);
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_valid = 1'b1;
                if (bus.i_mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_rready = 1'b1;
                if (bus.i_mem_rvalid) begin
                    // Write acks are captured too; the owner simply ignores the data.
                    rdata_d = bus.i_mem_rdata;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                for (int i = 0; i < REQ_NUM; i++) begin
                    rsp_valid[i] = (owner_q == IDX_W'(i));
                end
                if (bus.i_rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is combinational from the request inputs; mask it while reset is held
    // so every output is quiet for the whole reset window.
    assign bus.o_req_ready  = req_ready & {REQ_NUM{i_rstn}};
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_data   = rdata_q;
    assign bus.o_mem_valid  = mem_valid;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_we     = we_q;
    assign bus.o_mem_wdata  = wdata_q;
    assign bus.o_mem_rready = mem_rready;

endmodule

// File: tb/tb_kv_mem_arbiter.sv
// tb/tb_kv_mem_arbiter.sv - randomized self-checking bench for kv_mem_arbiter
module tb_kv_mem_arbiter;
    import kv_mem_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LS = 4;
    localparam int LW = DW * LS;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    kv_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .REQ_NUM(N)) bus ();

    kv_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .REQ_NUM(N)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0]  pend;
    logic [AW-1:0] raddr [N];
    logic          rwe   [N];
    logic [LW-1:0] rwd   [N];
    int            ptr_m;
    logic [LW-1:0] mem_m [logic [AW-1:0]];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {4{a ^ 32'hDEAD_BEEF}};
    endfunction

    // Round-robin reference: first pending requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (p[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic we, input logic [LW-1:0] d);
        pend[i]  = 1'b1;
        raddr[i] = a;
        rwe[i]   = we;
        rwd[i]   = d;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.i_req_valid[i] = pend[i];
            bus.i_req_addr[i]  = raddr[i];
            bus.i_req_we[i]    = rwe[i];
            bus.i_req_wdata[i] = rwd[i];
        end
    endtask

    task automatic arrivals();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0)
                set_req(i, {24'h0, 4'($urandom_range(0, 15)), 4'h0}, 1'($urandom_range(0, 1)), rand_line());
        end
    endtask

    task automatic idle_stray();
        bus.i_req_valid  = '0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rand_line();
        #1;
        check("idle_stray_rready", bus.o_mem_rready, 0);
        check("idle_stray_rsp", bus.o_rsp_valid, 0);
        @(negedge clk);
        bus.i_mem_rvalid = 1'b0;
        #1;
        check("idle_stray_memv", bus.o_mem_valid, 0);
        check("idle_stray_rsp2", bus.o_rsp_valid, 0);
    endtask

    // One transaction, starting on a negedge in IDLE. All waits are fixed counts.
    task automatic do_txn(input int mdly, input int rvdly, input int rsdly,
                          input bit stray, input bit rst_wait, input bit arrive);
        int g;
        logic [N-1:0]  own;
        logic [AW-1:0] ca;
        logic          cw;
        logic [LW-1:0] cd, rd;
        g = rr_pick(pend, ptr_m);
        if (g < 0) return;
        own = '0;
        own[g] = 1'b1;
        ca = raddr[g]; cw = rwe[g]; cd = rwd[g];
        drive_reqs();
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = stray;
        bus.i_rsp_ready  = '0;
        #1;
        check("req_ready_grant", bus.o_req_ready, own);
        check("idle_mem_valid", bus.o_mem_valid, 0);
        @(negedge clk);
        pend[g] = 1'b0;
        ptr_m = (g + 1) % N;
        if (arrive) arrivals();
        drive_reqs();
        // ISSUE
        for (int k = 0; k <= mdly; k++) begin
            bus.i_mem_ready  = (k == mdly);
            bus.i_mem_rvalid = stray && (k == 0);
            #1;
            check("issue_valid", bus.o_mem_valid, 1);
            check("issue_addr", bus.o_mem_addr, ca);
            check("issue_we", bus.o_mem_we, cw);
            check("issue_wdata", bus.o_mem_wdata, cd);
            check("issue_rready", bus.o_mem_rready, 0);
            check("issue_req_ready", bus.o_req_ready, 0);
            check("issue_rsp", bus.o_rsp_valid, 0);
            @(negedge clk);
        end
        bus.i_mem_ready = 1'b0;
        // WAIT
        rd = cw ? rand_line() : mem_read(ca);
        for (int k = 0; k <= rvdly; k++) begin
            if (rst_wait) begin
                bus.i_mem_rvalid = 1'b0;
                rstn = 1'b0;
                #1;
                check("rst_req_ready", bus.o_req_ready, 0);
                check("rst_mem_valid", bus.o_mem_valid, 0);
                check("rst_mem_rready", bus.o_mem_rready, 0);
                check("rst_rsp_valid", bus.o_rsp_valid, 0);
                check("rst_mem_addr", bus.o_mem_addr, 0);
                check("rst_mem_we", bus.o_mem_we, 0);
                check("rst_mem_wdata", bus.o_mem_wdata, 0);
                check("rst_rsp_data", bus.o_rsp_data, 0);
                ptr_m = 0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            bus.i_mem_rvalid = (k == rvdly);
            bus.i_mem_rdata  = (k == rvdly) ? rd : ~rd;
            #1;
            check("wait_rready", bus.o_mem_rready, 1);
            check("wait_mem_valid", bus.o_mem_valid, 0);
            check("wait_rsp", bus.o_rsp_valid, 0);
            check("wait_req_ready", bus.o_req_ready, 0);
            @(negedge clk);
        end
        if (cw) mem_m[ca] = cd;
        // RETURN
        for (int k = 0; k <= rsdly; k++) begin
            bus.i_mem_rvalid = 1'($urandom_range(0, 1));
            bus.i_mem_rdata  = rand_line();
            bus.i_rsp_ready  = ((k == rsdly) ? own : '0) | (N'($urandom) & ~own);
            #1;
            check("rsp_valid", bus.o_rsp_valid, own);
            check("rsp_data", bus.o_rsp_data, rd);
            check("ret_req_ready", bus.o_req_ready, 0);
            check("ret_mem_rready", bus.o_mem_rready, 0);
            @(negedge clk);
        end
        bus.i_rsp_ready  = '0;
        bus.i_mem_rvalid = 1'b0;
        #1;
        check("rsp_drop", bus.o_rsp_valid, 0);
    endtask

    initial begin
        rstn = 1'b0;
        pend = '0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            raddr[i] = '0; rwe[i] = 1'b0; rwd[i] = '0;
        end
        drive_reqs();
        bus.i_rsp_ready  = '0;
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        @(negedge clk);
        #1;
        check("reset_req_ready", bus.o_req_ready, 0);
        check("reset_mem_valid", bus.o_mem_valid, 0);
        check("reset_rsp_valid", bus.o_rsp_valid, 0);
        check("reset_mem_rready", bus.o_mem_rready, 0);
        check("reset_rsp_data", bus.o_rsp_data, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Single read with zero-latency memory.
        mem_m[32'h100] = {4{32'hDEAD_BEEF}};
        set_req(0, 32'h100, 1'b0, '0);
        do_txn(0, 0, 0, 0, 0, 0);

        // Both requesters held valid: grants must alternate.
        for (int r = 0; r < 6; r++) begin
            if (!pend[0]) set_req(0, 32'h140 + r * 16, 1'b0, '0);
            if (!pend[1]) set_req(1, 32'h180 + r * 16, 1'b1, rand_line());
            do_txn(0, 0, 0, 0, 0, 0);
        end
        pend = '0;

        // Write with memory stalling the command for three cycles, then read it back.
        set_req(1, 32'h200, 1'b1, rand_line());
        do_txn(3, 0, 0, 0, 0, 0);
        set_req(0, 32'h200, 1'b0, '0);
        do_txn(0, 2, 0, 0, 0, 0);

        // Response held off five cycles while other requests wait.
        set_req(0, 32'h300, 1'b0, '0);
        do_txn(0, 1, 5, 0, 0, 1);
        pend = '0;

        // Stray memory responses in IDLE and ISSUE.
        idle_stray();
        set_req(1, 32'h340, 1'b0, '0);
        do_txn(2, 1, 0, 1, 0, 0);

        // Reset during WAIT, then pointer must restart at 0.
        set_req(0, 32'h380, 1'b0, '0);
        do_txn(0, 0, 0, 0, 0, 0);
        set_req(0, 32'h3C0, 1'b0, '0);
        set_req(1, 32'h3C0, 1'b0, '0);
        do_txn(0, 0, 0, 0, 1, 0);
        set_req(0, 32'h100, 1'b0, '0);
        do_txn(0, 0, 0, 0, 0, 0);
        do_txn(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int r = 0; r < 80; r++) begin
            if (pend == '0) begin
                idle_stray();
                arrivals();
            end
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
